// File: rtl/alu_exec_unit_if.sv
// Handshake and data bus between the issue stage and the execute-stage ALU.
// The master side presents operations and accepts results.
// The slave side is the ALU.
interface alu_exec_unit_if #(
    parameter int XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      alu_control;
    logic            word_op;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;

    modport master (
        output in_valid, alu_control, word_op, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, zero, illegal
    );

    modport slave (
        input  in_valid, alu_control, word_op, op_a, op_b, out_ready,
        output in_ready, out_valid, result, zero, illegal
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU.
// Logic and arithmetic ops finish in one cycle.
// SLL/SRL run through an iterative shifter that moves at most SHIFT_STEP bits per cycle.
// The unit holds one operation at a time: it is accepted in IDLE, may spend cycles in SHIFT,
// and is presented in DONE until it is retired.
module alu_exec_unit #(
    parameter int XLEN       = 64,
    parameter int SHIFT_STEP = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    alu_exec_unit_if.slave     bus
);
    localparam int SW = $clog2(XLEN + 1);
    localparam logic [SW-1:0] STEP_W = SW'(SHIFT_STEP);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_SLL  = 4'b0110;
    localparam logic [3:0] OP_SRL  = 4'b0111;
    localparam logic [3:0] OP_PASS = 4'b1000;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state, state_nxt;
    logic [XLEN-1:0] acc, acc_step, load_val, alu_res, alu_fin;
    logic [SW-1:0]   remaining, step, shamt;
    logic            shift_left, word_q;
    logic [XLEN-1:0] result_q;
    logic            zero_q, illegal_q, illegal_nxt;
    logic            accept, is_shift, slt_bit;

    // Word results are sign-extended from bit 31; this is applied to every op.
    function automatic logic [XLEN-1:0] fin(input logic [XLEN-1:0] r, input logic w);
        return w ? {{(XLEN-32){r[31]}}, r[31:0]} : r;
    endfunction

    // A flush cycle never accepts, even if the unit is idle and in_valid is high.
    assign accept   = bus.in_valid && bus.in_ready && !flush;
    assign is_shift = (bus.alu_control == OP_SLL) || (bus.alu_control == OP_SRL);
    assign shamt    = bus.word_op ? SW'(bus.op_b[4:0]) : SW'(bus.op_b[5:0]);

    // SRLW must zero-fill from bit 31, so the upper half is cleared before shifting.
    // SLLW needs no masking because only bits [31:0] survive the final sign-extension.
    assign load_val = (bus.word_op && bus.alu_control == OP_SRL)
                    ? {{(XLEN-32){1'b0}}, bus.op_a[31:0]} : bus.op_a;

    // Single-cycle ALU result, computed from the live inputs and captured at accept.
    always_comb begin
        alu_res     = '0;
        illegal_nxt = 1'b0;
        slt_bit     = bus.word_op ? ($signed(bus.op_a[31:0]) < $signed(bus.op_b[31:0]))
                                  : ($signed(bus.op_a) < $signed(bus.op_b));
        case (bus.alu_control)
            OP_ADD:         alu_res = bus.op_a + bus.op_b;
            OP_SUB:         alu_res = bus.op_a - bus.op_b;
            OP_AND:         alu_res = bus.op_a & bus.op_b;
            OP_OR:          alu_res = bus.op_a | bus.op_b;
            OP_XOR:         alu_res = bus.op_a ^ bus.op_b;
            OP_SLT:         alu_res = {{(XLEN-1){1'b0}}, slt_bit};
            OP_SLL, OP_SRL: alu_res = load_val;  // used only when shamt == 0
            OP_PASS:        alu_res = bus.op_b;
            default:        illegal_nxt = 1'b1;
        endcase
        alu_fin = fin(alu_res, bus.word_op);
    end

    // One shifter step: min(SHIFT_STEP, remaining) positions in the latched direction.
    always_comb begin
        step     = (remaining > STEP_W) ? STEP_W : remaining;
        acc_step = shift_left ? (acc << step) : (acc >> step);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic. Flush overrides every transition.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (is_shift && shamt != '0) ? SHIFT : DONE;
            SHIFT:   if (remaining == step) state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    // Datapath: operand capture at accept, shifter iteration, and result/flag capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= '0;
            remaining  <= '0;
            shift_left <= 1'b0;
            word_q     <= 1'b0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            illegal_q  <= 1'b0;
        end else if (!flush) begin
            if (state == IDLE && accept) begin
                acc        <= load_val;
                remaining  <= shamt;
                shift_left <= (bus.alu_control == OP_SLL);
                word_q     <= bus.word_op;
                if (!(is_shift && shamt != '0)) begin
                    result_q  <= alu_fin;
                    zero_q    <= (alu_fin == '0);
                    illegal_q <= illegal_nxt;
                end
            end else if (state == SHIFT) begin
                acc       <= acc_step;
                remaining <= remaining - step;
                if (remaining == step) begin
                    result_q  <= fin(acc_step, word_q);
                    zero_q    <= (fin(acc_step, word_q) == '0);
                    illegal_q <= 1'b0;
                end
            end
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.illegal   = illegal_q;
endmodule
